// File: rtl/nios2_system_multi_timer.sv
// nios2_system_multi_timer: NUM_CH independent down-counting interval timers
// on one Avalon-MM slave, each with prescaler, snapshot and interrupt.
module nios2_system_multi_timer #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 32,
    parameter int PRESC_W        = 16,
    parameter int DEFAULT_PERIOD = 49999,
    localparam int AW            = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    localparam logic [2:0] R_STATUS  = 3'd0;
    localparam logic [2:0] R_CONTROL = 3'd1;
    localparam logic [2:0] R_PERIOD  = 3'd2;
    localparam logic [2:0] R_SNAP    = 3'd3;
    localparam logic [2:0] R_PRESC   = 3'd4;

    logic [CNT_W-1:0]   period [NUM_CH];
    logic [CNT_W-1:0]   count  [NUM_CH];
    logic [CNT_W-1:0]   snap   [NUM_CH];
    logic [PRESC_W-1:0] presc  [NUM_CH];
    logic [PRESC_W-1:0] pcnt   [NUM_CH];

    logic [NUM_CH-1:0] to;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] ito;
    logic [NUM_CH-1:0] cont;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tevt;
    logic [NUM_CH-1:0] wsel;

    logic [AW-1:0] ch_idx;
    logic [2:0]    reg_idx;
    logic          wr;
    logic [31:0]   rd_mux;
    logic          unused_ok;

    assign wr        = chipselect && !write_n;
    assign ch_idx    = address >> 3;
    assign reg_idx   = address[2:0];
    assign unused_ok = ^{read_n, writedata};

    always_comb begin
        tick = '0;
        tevt = '0;
        wsel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i] = run[i] && (pcnt[i] == presc[i]);
            tevt[i] = tick[i] && (count[i] == '0);
            wsel[i] = wr && (ch_idx == AW'(i));
        end
    end

    // Unmatched channel indices and reg indices 5..7 fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == AW'(i)) begin
                case (reg_idx)
                    R_STATUS:  rd_mux = {30'd0, run[i], to[i]};
                    R_CONTROL: rd_mux = {30'd0, cont[i], ito[i]};
                    R_PERIOD:  rd_mux = 32'(period[i]);
                    R_SNAP:    rd_mux = 32'(snap[i]);
                    R_PRESC:   rd_mux = 32'(presc[i]);
                    default:   rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            to       <= '0;
            run      <= '0;
            ito      <= '0;
            cont     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= DEF_P;
                count[i]  <= DEF_P;
                snap[i]   <= '0;
                presc[i]  <= '0;
                pcnt[i]   <= '0;
            end
        end else begin
            readdata <= rd_mux;
            for (int i = 0; i < NUM_CH; i++) begin
                if (run[i]) begin
                    pcnt[i] <= tick[i] ? '0 : pcnt[i] + 1'b1;
                end else begin
                    pcnt[i] <= '0;
                end

                if (tick[i]) begin
                    if (count[i] == '0) begin
                        count[i] <= period[i];
                        if (!cont[i]) run[i] <= 1'b0;
                    end else begin
                        count[i] <= count[i] - 1'b1;
                    end
                end

                // A clear coinciding with a timeout must not lose the event.
                if (wsel[i] && reg_idx == R_STATUS) to[i] <= 1'b0;
                if (tevt[i]) to[i] <= 1'b1;

                if (wsel[i]) begin
                    case (reg_idx)
                        R_CONTROL: begin
                            ito[i]  <= writedata[0];
                            cont[i] <= writedata[1];
                            if (writedata[3]) run[i] <= 1'b0;
                            if (writedata[2]) begin
                                run[i]  <= 1'b1;
                                pcnt[i] <= '0;
                            end
                        end
                        R_PERIOD: begin
                            period[i] <= writedata[CNT_W-1:0];
                            count[i]  <= writedata[CNT_W-1:0];
                            run[i]    <= 1'b0;
                            pcnt[i]   <= '0;
                        end
                        R_SNAP: begin
                            snap[i] <= count[i];
                        end
                        R_PRESC: begin
                            presc[i] <= writedata[PRESC_W-1:0];
                            pcnt[i]  <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign irq_vec = to & ito;
    assign irq     = |irq_vec;

endmodule

// File: tb/tb_nios2_system_multi_timer.sv
// tb_nios2_system_multi_timer: directed register vectors plus hand-timed
// sequences for timeout latency, one-shot, set-wins and snapshot.
module tb_nios2_system_multi_timer;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 16;
    localparam int AW      = $clog2(NUM_CH) + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    nios2_system_multi_timer #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .PRESC_W(PRESC_W),
        .DEFAULT_PERIOD(49999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .read_n(read_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_vec(irq_vec)
    );

    function automatic logic [AW-1:0] ra(input int ch, input int r);
        return AW'(ch * 8 + r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    // Called just after a negedge; the write lands on the next posedge.
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d);
        vecs.push_back('{w, a, d});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        address    = '0;
        writedata  = '0;
        idle(3);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec), 32'd0);
        reset = 1'b0;

        add(0, ra(0, 2), 32'd49999);
        add(0, ra(0, 0), 32'd0);
        add(0, ra(1, 2), 32'd49999);
        add(0, ra(2, 1), 32'd0);
        add(0, ra(1, 4), 32'd0);
        add(0, ra(0, 3), 32'd0);
        add(1, ra(2, 2), 32'h1234_ABCD);
        add(0, ra(2, 2), 32'h0000_ABCD);
        add(1, ra(2, 4), 32'hFFFF_0003);
        add(0, ra(2, 4), 32'd3);
        add(1, ra(2, 1), 32'hF);
        add(0, ra(2, 1), 32'd3);
        add(0, ra(2, 0), 32'd2);
        add(1, ra(2, 1), 32'h8);
        add(0, ra(2, 0), 32'd0);
        add(0, ra(2, 1), 32'd0);
        add(1, ra(2, 6), 32'hFFFF_FFFF);
        add(0, ra(2, 6), 32'd0);
        add(0, ra(2, 5), 32'd0);
        add(0, ra(2, 7), 32'd0);
        add(1, ra(3, 2), 32'd5);
        add(1, ra(3, 1), 32'd4);
        add(0, ra(3, 2), 32'd0);
        add(0, ra(3, 0), 32'd0);
        add(0, ra(2, 2), 32'h0000_ABCD);
        add(0, ra(0, 2), 32'd49999);
        add(0, ra(0, 0), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, d);
                chk($sformatf("vec%0d", i), d, vecs[i].data);
            end
        end

        // ch0 continuous, period 9, no prescale: timeout every 10 clocks
        wr(ra(0, 2), 32'd9);
        wr(ra(0, 4), 32'd0);
        wr(ra(0, 1), 32'h7);
        idle(9);
        chk("c0_first_early", 32'(irq_vec[0]), 32'd0);
        idle(1);
        chk("c0_first", 32'(irq_vec[0]), 32'd1);
        chk("c0_irq", 32'(irq), 32'd1);
        wr(ra(0, 0), 32'd0);
        chk("c0_clear", 32'(irq_vec[0]), 32'd0);
        idle(8);
        chk("c0_second_early", 32'(irq_vec[0]), 32'd0);
        idle(1);
        chk("c0_second", 32'(irq_vec[0]), 32'd1);
        rd(ra(0, 0), d);
        chk("c0_status_run", d, 32'd3);
        wr(ra(0, 1), 32'h8);
        wr(ra(0, 0), 32'd0);
        chk("c0_stopped_irq", 32'(irq), 32'd0);

        // ch1 one-shot, period 3, prescale 4: timeout after 20 clocks
        wr(ra(1, 2), 32'd3);
        wr(ra(1, 4), 32'd4);
        wr(ra(1, 1), 32'h5);
        idle(19);
        chk("c1_os_early", 32'(irq_vec[1]), 32'd0);
        idle(1);
        chk("c1_os_to", 32'(irq_vec[1]), 32'd1);
        chk("c1_irq", 32'(irq), 32'd1);
        rd(ra(1, 0), d);
        chk("c1_status", d, 32'd1);
        wr(ra(1, 3), 32'd0);
        rd(ra(1, 3), d);
        chk("c1_count_reload", d, 32'd3);
        wr(ra(1, 0), 32'd0);
        chk("c1_clear", 32'(irq_vec[1]), 32'd0);
        chk("irq_drop", 32'(irq), 32'd0);
        idle(25);
        chk("c1_no_retrig", 32'(irq_vec[1]), 32'd0);

        // STATUS write landing on the timeout edge
        wr(ra(1, 4), 32'd0);
        wr(ra(1, 1), 32'h5);
        idle(3);
        chk("c1_pre_evt", 32'(irq_vec[1]), 32'd0);
        wr(ra(1, 0), 32'd0);
        chk("c1_set_wins", 32'(irq_vec[1]), 32'd1);
        wr(ra(1, 0), 32'd0);
        chk("c1_clear2", 32'(irq_vec[1]), 32'd0);

        // snapshot mid-count, then PERIOD write mid-count
        wr(ra(1, 2), 32'd100);
        wr(ra(1, 1), 32'h5);
        idle(10);
        wr(ra(1, 3), 32'd0);
        rd(ra(1, 3), d);
        chk("c1_snap_mid", d, 32'd90);
        wr(ra(1, 2), 32'd7);
        rd(ra(1, 0), d);
        chk("c1_period_stops", d, 32'd0);
        wr(ra(1, 3), 32'd0);
        rd(ra(1, 3), d);
        chk("c1_period_load", d, 32'd7);
        idle(20);
        wr(ra(1, 3), 32'd0);
        rd(ra(1, 3), d);
        chk("c1_period_hold", d, 32'd7);
        rd(ra(1, 2), d);
        chk("c1_period_rd", d, 32'd7);

        // ch0 and ch2 time out on the same edge
        wr(ra(2, 4), 32'd0);
        wr(ra(2, 2), 32'd3);
        wr(ra(0, 2), 32'd4);
        wr(ra(0, 1), 32'h5);
        wr(ra(2, 1), 32'h5);
        idle(3);
        chk("dual_early", 32'(irq_vec), 32'd0);
        idle(1);
        chk("dual_both", 32'(irq_vec), 32'd5);
        chk("dual_irq", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
